prog_seq: RTL

PROG_SEQ -- requirements
Module: prog_seq

---
 rtl/prog_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program sequencer: launches one of three programs and steps the PC through it
module prog_seq #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       prog_sel_i,
  input  logic             stall_i,
  input  logic             halt_i,
  input  logic             branch_en_i,
  input  logic             branch_taken_i,
  input  logic [2:0]       branch_idx_i,
  input  logic [PC_W-1:0]  lut_target_i,
  output logic [2:0]       lut_addr_o,
  output logic [1:0]       prog_state_o,
  output logic [PC_W-1:0]  pc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ack_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [1:0]       prog_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_inc_d;

  // Saturating increment of the RUN-cycle counter
  always_comb begin
    cnt_inc_d = cnt_q;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_inc_d = cnt_q + 1'b1;
    end
  end

  // Sequencer FSM: launch handshake, entry-point load, then Stall > Halt > branch > increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pc_q    <= '0;
      prog_q  <= 2'b00;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            if (prog_sel_i != 2'b00) begin
              prog_q  <= prog_sel_i;
              ack_q   <= 1'b1;
              cnt_q   <= '0;
              state_q <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          pc_q    <= lut_target_i;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_inc_d;
          if (stall_i) begin
            pc_q <= pc_q;
          end else if (halt_i) begin
            state_q <= DONE;
          end else if (branch_en_i && branch_taken_i) begin
            pc_q <= lut_target_i;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // LUT index follows the instruction only while running; LOAD reads the entry slot 0
  always_comb begin
    lut_addr_o = 3'b000;
    if (state_q == RUN) begin
      lut_addr_o = branch_idx_i;
    end
  end

  assign prog_state_o  = prog_q;
  assign pc_o          = pc_q;
  assign busy_o        = (state_q == LOAD) || (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign ack_o         = ack_q;
  assign err_o         = err_q;
  assign cycle_count_o = cnt_q;

endmodule
